// File: rtl/cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : cmp_seq (with helper cmp_byte)
// Purpose  : Multi-byte magnitude comparator. One N-bit comparator is reused
//            across the W bytes of a cell, walking from the MSB byte down.
//            The MSB byte is compared signed when s=1; lower bytes are always
//            compared unsigned, which together gives a full-width compare.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            req  - start request, accepted only while rdy=1
//            s    - 0 unsigned, 1 signed (sampled at accept)
//            a, b - N*W-bit operand cells (sampled at accept)
//            rdy  - high in IDLE
//            done - one-cycle pulse when o holds a new result
//            o    - registered {eq,ne,lt,le,gt,ge}
// Config   : EFORTH1_CMP_EARLY_EXIT_EN - when defined, the operation ends at
//            the first unequal byte; otherwise all W bytes are always walked.
//            Results are identical either way, only latency differs.
// Revision : 1.0 - initial release
// ============================================================================

module cmp_byte #(
   parameter int N = 8
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         sgn,
   output logic         eq,
   output logic         lt
);
   assign eq = (x == y);

   always_comb begin
      if (sgn) lt = ($signed(x) < $signed(y));
      else     lt = (x < y);
   end
endmodule

module cmp_seq #(
   parameter int N = 8,
   parameter int W = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req,
   input  logic           s,
   input  logic [N*W-1:0] a,
   input  logic [N*W-1:0] b,
   output logic           rdy,
   output logic           done,
   output logic [5:0]     o
);
   localparam int IW = (W > 1) ? $clog2(W) : 1;

   // {eq,ne,lt,le,gt,ge} for an equal cell
   localparam logic [5:0] c_EQ_RES = 6'b100101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state, w_state_nx;
   logic [IW-1:0]    r_idx, w_idx_nx;
   logic [5:0]       r_o, w_o_nx;
   logic             r_s;
   logic [N*W-1:0]   r_a, r_b;
   logic             w_load;

   logic [N-1:0]     w_x, w_y;
   logic             w_sgn, w_eq, w_lt;

   // Result for an unequal cell given the deciding byte's lt
   function automatic logic [5:0] f_ne_res(input logic lt);
      return {1'b0, 1'b1, lt, lt, ~lt, ~lt};
   endfunction

   // Byte slice selection for the single comparator
   always_comb begin
      w_x = '0;
      w_y = '0;
      for (int i = 0; i < W; i++) begin
         if (r_idx == IW'(i)) begin
            w_x = r_a[i*N +: N];
            w_y = r_b[i*N +: N];
         end
      end
   end

   // Only the most significant byte carries the sign
   assign w_sgn = r_s & (r_idx == IW'(W-1));

   cmp_byte #(.N(N)) u_cmp (
      .x   (w_x),
      .y   (w_y),
      .sgn (w_sgn),
      .eq  (w_eq),
      .lt  (w_lt)
   );

`ifndef EFORTH1_CMP_EARLY_EXIT_EN
   // Remembers the first unequal byte seen while the walk continues
   logic r_found, w_found_nx;
   logic r_lt,    w_lt_nx;
   logic w_first_lt, w_any_ne;

   assign w_first_lt = r_found ? r_lt : w_lt;
   assign w_any_ne   = r_found | ~w_eq;
`endif

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_o_nx     = r_o;
      w_load     = 1'b0;
`ifndef EFORTH1_CMP_EARLY_EXIT_EN
      w_found_nx = r_found;
      w_lt_nx    = r_lt;
`endif
      case (r_state)
         IDLE: begin
            if (req) begin
               w_load     = 1'b1;
               w_idx_nx   = IW'(W-1);
               w_state_nx = RUN;
`ifndef EFORTH1_CMP_EARLY_EXIT_EN
               w_found_nx = 1'b0;
               w_lt_nx    = 1'b0;
`endif
            end
         end
         RUN: begin
`ifdef EFORTH1_CMP_EARLY_EXIT_EN
            if (!w_eq) begin
               w_o_nx     = f_ne_res(w_lt);
               w_state_nx = DONE;
            end else if (r_idx == '0) begin
               w_o_nx     = c_EQ_RES;
               w_state_nx = DONE;
            end else begin
               w_idx_nx   = r_idx - 1'b1;
            end
`else
            if (!r_found && !w_eq) begin
               w_found_nx = 1'b1;
               w_lt_nx    = w_lt;
            end
            if (r_idx == '0) begin
               w_o_nx     = w_any_ne ? f_ne_res(w_first_lt) : c_EQ_RES;
               w_state_nx = DONE;
            end else begin
               w_idx_nx   = r_idx - 1'b1;
            end
`endif
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_o     <= '0;
         r_s     <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_o     <= w_o_nx;
         if (w_load) begin
            r_s <= s;
            r_a <= a;
            r_b <= b;
         end
      end
   end

`ifndef EFORTH1_CMP_EARLY_EXIT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_found <= 1'b0;
         r_lt    <= 1'b0;
      end else begin
         r_found <= w_found_nx;
         r_lt    <= w_lt_nx;
      end
   end
`endif

   // Status outputs decode directly from the state register so reset
   // takes effect on them immediately.
   assign rdy  = (r_state == IDLE);
   assign done = (r_state == DONE);
   assign o    = r_o;

endmodule
`default_nettype wire

// File: tb/tb_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_seq
// Purpose  : Self-checking bench for cmp_seq (N=8, W=2). Expected results and
//            latencies come from a full-width reference compare and are queued
//            at accept, then popped when done pulses.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_seq;
   localparam int N  = 8;
   localparam int W  = 2;
   localparam int CW = N * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          s   = 1'b0;
   logic [CW-1:0] a   = '0;
   logic [CW-1:0] b   = '0;
   logic          rdy, done;
   logic [5:0]    o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [5:0] res;
      int         lat;
   } exp_t;
   exp_t sb[$];

   cmp_seq #(.N(N), .W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .s    (s),
      .a    (a),
      .b    (b),
      .rdy  (rdy),
      .done (done),
      .o    (o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: one full-width compare of the whole cell
   function automatic logic [5:0] ref_cmp(input logic sg, input logic [CW-1:0] x, input logic [CW-1:0] y);
      logic eq, lt;
      eq = (x == y);
      lt = sg ? ($signed(x) < $signed(y)) : (x < y);
      return {eq, ~eq, lt, lt | eq, ~(lt | eq), ~lt};
   endfunction

   // Cycles from the accept cycle to the done cycle: bytes walked plus one
   function automatic int ref_lat(input logic [CW-1:0] x, input logic [CW-1:0] y);
      int k;
      k = W;
`ifdef EFORTH1_CMP_EARLY_EXIT_EN
      for (int i = W - 1; i >= 0; i--) begin
         if (x[i*N +: N] != y[i*N +: N]) begin
            k = W - i;
            break;
         end
      end
`endif
      return k + 1;
   endfunction

   // Starts one operation from IDLE (called at posedge+1) and waits for done.
   // hold keeps req high while busy; swap changes a/b/s during RUN.
   task automatic run_op(input string tag, input logic sg, input logic [CW-1:0] x,
                         input logic [CW-1:0] y, input bit hold, input bit swap);
      exp_t       e, got;
      logic [5:0] prev_o;
      int         cyc;
      bit         seen;
      e.res = ref_cmp(sg, x, y);
      e.lat = ref_lat(x, y);
      check({tag, "_rdy_idle"}, rdy, 1'b1);
      s = sg; a = x; b = y; req = 1'b1;
      sb.push_back(e);
      prev_o = o;
      @(posedge clk); #1;
      cyc  = 1;
      seen = 1'b0;
      if (!hold) req = 1'b0;
      if (swap) begin
         a = ~x; b = x; s = ~sg;
      end
      for (int t = 0; t < 20; t++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         check({tag, "_o_hold"}, o, prev_o);
         check({tag, "_rdy_busy"}, rdy, 1'b0);
         @(posedge clk); #1;
         cyc++;
      end
      // Drop req in the DONE cycle so the returning IDLE cycle sees none
      req = 1'b0;
      check({tag, "_done_seen"}, seen, 1'b1);
      if (seen && sb.size() > 0) begin
         got = sb.pop_front();
         check({tag, "_o"}, o, got.res);
         check({tag, "_lat"}, cyc, got.lat);
         check({tag, "_rdy_done"}, rdy, 1'b0);
      end
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_o_kept"}, o, e.res);
   endtask

   initial begin
      logic [CW-1:0] ra, rb;
      logic          rs;

      #1;
      check("reset_rdy", rdy, 1'b1);
      check("reset_done", done, 1'b0);
      check("reset_o", o, 6'b000000);
      @(posedge clk); #1;
      rst = 1'b0;

      // First edge after reset release accepts a request
      run_op("eq_1234", 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0);
      check("eq_1234_val", o, 6'b100101);
      run_op("s_ff00_0001", 1'b1, 16'hFF00, 16'h0001, 1'b0, 1'b0);
      check("s_ff00_val", o, 6'b011100);
      run_op("s_0080_0001", 1'b1, 16'h0080, 16'h0001, 1'b0, 1'b0);
      check("s_0080_val", o, 6'b010011);
      run_op("u_ff00_0001", 1'b0, 16'hFF00, 16'h0001, 1'b0, 1'b0);
      check("u_ff00_val", o, 6'b010011);
      run_op("s_lowdiff", 1'b1, 16'h8001, 16'h80FF, 1'b0, 1'b0);
      run_op("u_msb_lt", 1'b0, 16'h0112, 16'h0211, 1'b0, 1'b0);

      // req held through the busy period with operands changed during RUN
      run_op("hold_swap", 1'b0, 16'h5A10, 16'h5A20, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("hold_no_extra_done", done, 1'b0);
         @(posedge clk); #1;
      end

      for (int i = 0; i < 8; i++) begin
         ra = CW'($urandom);
         rb = (i % 2 == 0) ? {ra[CW-1 -: N], N'($urandom)} : CW'($urandom);
         rs = 1'($urandom);
         run_op("rand", rs, ra, rb, 1'b0, 1'b0);
      end

      // Reset pulse during RUN: immediate clear, no done afterwards
      check("pre_rst_o_nonzero", (o != 6'b0), 1'b1);
      s = 1'b0; a = 16'h0100; b = 16'h0200; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      check("run_before_rst", rdy, 1'b0);
      rst = 1'b1;
      #1;
      check("rst_o", o, 6'b000000);
      check("rst_rdy", rdy, 1'b1);
      check("rst_done", done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("post_rst_no_done", done, 1'b0);
         check("post_rst_o", o, 6'b000000);
         @(posedge clk); #1;
      end
      run_op("after_rst", 1'b1, 16'h7F00, 16'h8000, 1'b0, 1'b0);

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
